// File: rtl/trap_ctrl_pkg.sv
// Shared constants, FSM state type and mstatus update helpers for the machine-mode
// trap sequencer.
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [4:0] CAUSE_M_EXT_IRQ = 5'd11;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StTEpc    = 3'd1,
        StTCause  = 3'd2,
        StTStatus = 3'd3,
        StTJump   = 3'd4,
        StRStatus = 3'd5,
        StRJump   = 3'd6
    } state_e;

    // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode as previous mode.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes exceptions/interrupts and mret at WB, flushes the
// pipeline, sequences mepc/mcause/mstatus writes over the shared CSR port and redirects fetch.
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_exc_valid,
    input  logic [4:0]  wb_exc_cause,
    input  logic        wb_mret,
    input  logic        wb_csr_we,
    input  logic [11:0] wb_csr_waddr,
    input  logic [31:0] wb_csr_wdata,
    input  logic        irq_ext,
    input  logic [31:0] csr_mstatus,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        flush,
    output logic        kill_wb,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [5:0]  cause_q, cause_d;

    logic        take;
    logic        mret_go;
    logic [31:0] mtvec_base;
    logic [31:0] trap_target;

    // Only the aligned part of mepc forms the return target.
    logic unused_mepc;
    assign unused_mepc = ^csr_mepc[1:0];

    assign take    = wb_valid && (wb_exc_valid || (irq_ext && csr_mstatus[MSTATUS_MIE]));
    assign mret_go = wb_valid && wb_mret && !take;

    assign mtvec_base  = {csr_mtvec[31:2], 2'b00};
    assign trap_target = (csr_mtvec[1:0] == 2'b01 && cause_q[5])
                       ? mtvec_base + {25'd0, cause_q[4:0], 2'b00}
                       : mtvec_base;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            epc_q   <= 32'd0;
            cause_q <= 6'd0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        csr_we         = 1'b0;
        csr_waddr      = 12'd0;
        csr_wdata      = 32'd0;
        flush          = 1'b0;
        kill_wb        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        unique case (state_q)
            StIdle: begin
                // The WB instruction owns the CSR port unless it is being killed by a trap.
                kill_wb   = take;
                flush     = take || mret_go;
                csr_we    = wb_csr_we && wb_valid && !take;
                csr_waddr = wb_csr_waddr;
                csr_wdata = wb_csr_wdata;
                if (take) begin
                    epc_d   = wb_pc;
                    cause_d = wb_exc_valid ? {1'b0, wb_exc_cause} : {1'b1, CAUSE_M_EXT_IRQ};
                    state_d = StTEpc;
                end else if (mret_go) begin
                    state_d = StRStatus;
                end
            end
            StTEpc: begin
                flush     = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = epc_q;
                state_d   = StTCause;
            end
            StTCause: begin
                flush     = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = {cause_q[5], 26'd0, cause_q[4:0]};
                state_d   = StTStatus;
            end
            StTStatus: begin
                flush     = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = trap_mstatus(csr_mstatus);
                state_d   = StTJump;
            end
            StTJump: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = trap_target;
                state_d        = StIdle;
            end
            StRStatus: begin
                flush     = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = mret_mstatus(csr_mstatus);
                state_d   = StRJump;
            end
            StRJump: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = {csr_mepc[31:2], 2'b00};
                state_d        = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = (state_q != StIdle);

endmodule
